// File: rtl/cim_frame_ctl_pkg.sv
// Shared definitions for the cascaded-integrator monitor frame controller:
// frame geometry, minimum sample period and capture FSM encoding.
package cim_frame_ctl_pkg;

    localparam int NW         = 12;
    localparam int MIN_PERIOD = NW + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAP  = 2'd1,
        ST_DONE = 2'd2
    } cap_state_e;

endpackage

// File: rtl/cim_frame_ctl_if.sv
// Chain shift-out and host readout signals of the frame controller.
// The master side is the chain/host, the slave side is cim_frame_ctl.
interface cim_frame_ctl_if #(
    parameter int dw = 32
);
    logic [dw-1:0] sr_out;
    logic          sr_val;
    logic [3:0]    rd_addr;
    logic [dw-1:0] rd_data;
    logic          frame_ready;
    logic          frame_ack;

    modport master (
        output sr_out, sr_val, rd_addr, frame_ack,
        input  rd_data, frame_ready
    );

    modport slave (
        input  sr_out, sr_val, rd_addr, frame_ack,
        output rd_data, frame_ready
    );
endinterface

// File: rtl/cim_period_gen.sv
// Sample strobe generator: down-counter reloaded with max(period, min_period)-1,
// first strobe one cycle after enable rises.
module cim_period_gen
    import cim_frame_ctl_pkg::*;
#(
    parameter int pw         = 16,
    parameter int min_period = MIN_PERIOD
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [pw-1:0] period,
    output logic          sample
);

    logic [pw-1:0] cnt_q, cnt_d;
    logic [pw-1:0] eff_period;
    logic          sample_q, sample_d;

    always_comb begin
        eff_period = (period < pw'(min_period)) ? pw'(min_period) : period;
        cnt_d      = cnt_q;
        sample_d   = 1'b0;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q == '0) begin
            // period is only looked at here, so a new value waits for the reload
            sample_d = 1'b1;
            cnt_d    = eff_period - pw'(1);
        end else begin
            cnt_d = cnt_q - pw'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sample_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
        end
    end

    assign sample = sample_q;

endmodule

// File: rtl/cim_frame_ctl.sv
// Frame collector for the monitor chain: captures nw-word bursts into a
// double-buffered store and hands completed frames to the host.
module cim_frame_ctl
    import cim_frame_ctl_pkg::*;
#(
    parameter int dw = 32,
    parameter int nw = NW,
    parameter int pw = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [pw-1:0]    period,
    output logic             sample,
    cim_frame_ctl_if.slave   bus,
    output logic             overrun,
    output logic             frame_err,
    output logic [15:0]      frame_cnt
);

    localparam int         AW       = $clog2(2 * nw);
    localparam logic [3:0] LAST_IDX = 4'(nw - 1);

    cim_period_gen #(
        .pw         (pw),
        .min_period (nw + 2)
    ) u_period_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .period (period),
        .sample (sample)
    );

    // Bank b occupies words b*nw .. b*nw+nw-1 of the store.
    function automatic logic [AW-1:0] mem_addr(input logic bank, input logic [3:0] idx);
        return bank ? (AW'(nw) + AW'(idx)) : AW'(idx);
    endfunction

    cap_state_e    state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic          wr_bank_q, wr_bank_d;
    logic          frame_ready_q, frame_ready_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [dw-1:0] rd_data_q, rd_data_d;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [dw-1:0] wr_data;

    logic [dw-1:0] frame_mem [0:2*nw-1];

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wr_bank_d     = wr_bank_q;
        frame_ready_d = frame_ready_q;
        overrun_d     = overrun_q;
        frame_err_d   = frame_err_q;
        frame_cnt_d   = frame_cnt_q;
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_data       = bus.sr_out;

        // Host release comes first so that a same-cycle DONE or error can re-set flags.
        if (bus.frame_ack && frame_ready_q) begin
            frame_ready_d = 1'b0;
            overrun_d     = 1'b0;
            frame_err_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.sr_val) begin
                    wr_en   = 1'b1;
                    wr_addr = mem_addr(wr_bank_q, 4'd0);
                    idx_d   = 4'd1;
                    state_d = ST_CAP;
                end
            end
            ST_CAP: begin
                if (bus.sr_val) begin
                    wr_en   = 1'b1;
                    wr_addr = mem_addr(wr_bank_q, idx_q);
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 4'd0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    frame_err_d = 1'b1;
                    idx_d       = 4'd0;
                    state_d     = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!frame_ready_q || bus.frame_ack) begin
                    wr_bank_d     = ~wr_bank_q;
                    frame_ready_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + 16'd1;
                end else begin
                    overrun_d = 1'b1;
                end
                // A word arriving now opens the next burst in whichever bank is free.
                if (bus.sr_val) begin
                    wr_en   = 1'b1;
                    wr_addr = mem_addr(wr_bank_d, 4'd0);
                    idx_d   = 4'd1;
                    state_d = ST_CAP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                idx_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_data_d = '0;
        if (bus.rd_addr < 4'(nw)) begin
            rd_data_d = frame_mem[mem_addr(~wr_bank_q, bus.rd_addr)];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            frame_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= 4'd0;
            wr_bank_q     <= 1'b0;
            frame_ready_q <= 1'b0;
            overrun_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_cnt_q   <= 16'd0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wr_bank_q     <= wr_bank_d;
            frame_ready_q <= frame_ready_d;
            overrun_q     <= overrun_d;
            frame_err_q   <= frame_err_d;
            frame_cnt_q   <= frame_cnt_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.frame_ready = frame_ready_q;
    assign overrun         = overrun_q;
    assign frame_err       = frame_err_q;
    assign frame_cnt       = frame_cnt_q;

endmodule

// File: tb/tb_cim_frame_ctl.sv
// Directed bench for cim_frame_ctl: read-port vector table plus hand-written
// burst, period, overrun, error, ack and reset sequences.
module tb_cim_frame_ctl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] period;
    logic        sample;
    logic        overrun;
    logic        frame_err;
    logic [15:0] frame_cnt;

    cim_frame_ctl_if #(.dw(32)) bus ();

    cim_frame_ctl #(
        .dw (32),
        .nw (12),
        .pw (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .period    (period),
        .sample    (sample),
        .bus       (bus),
        .overrun   (overrun),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t rd_tbl [13];
    int      total = 0;
    int      bad   = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: got %h", nm, act);
        end
    endtask

    task automatic burst(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.sr_val = 1'b1;
            bus.sr_out = base + 32'(i);
            tick();
        end
        bus.sr_val = 1'b0;
        bus.sr_out = '0;
    endtask

    task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] e);
        bus.rd_addr = a;
        tick();
        chk(nm, bus.rd_data, e);
    endtask

    task automatic ack_pulse;
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
    endtask

    task automatic wait_sample(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sample && n < limit);
    endtask

    int n;

    initial begin
        for (int i = 0; i < 12; i++) begin
            rd_tbl[i].addr = 4'(i);
            rd_tbl[i].exp  = 32'h0000_1000 + 32'(i);
        end
        rd_tbl[12].addr = 4'd12;
        rd_tbl[12].exp  = 32'h0;

        rst_n         = 1'b1;
        enable        = 1'b0;
        period        = 16'd100;
        bus.sr_out    = '0;
        bus.sr_val    = 1'b0;
        bus.rd_addr   = '0;
        bus.frame_ack = 1'b0;

        #2 rst_n = 1'b0;
        #3;
        chk("rst_sample", 32'(sample), 32'd0);
        chk("rst_ready", 32'(bus.frame_ready), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_flags", {30'd0, overrun, frame_err}, 32'd0);
        chk("rst_rd_data", bus.rd_data, 32'd0);
        #10 rst_n = 1'b1;
        tick();

        // Frame A: ready appears one cycle after the DONE cycle
        burst(32'h0000_1000, 12);
        chk("a_ready_in_done", 32'(bus.frame_ready), 32'd0);
        tick();
        chk("a_ready", 32'(bus.frame_ready), 32'd1);
        chk("a_cnt", 32'(frame_cnt), 32'd1);

        for (int i = 0; i < 13; i++) begin
            rd_chk($sformatf("a_rd%0d", rd_tbl[i].addr), rd_tbl[i].addr, rd_tbl[i].exp);
        end
        bus.rd_addr = 4'd5;
        #1;
        chk("rd_latency_hold", bus.rd_data, 32'd0);
        tick();
        chk("rd_latency_new", bus.rd_data, 32'h0000_1005);

        // Sample period: first strobe one cycle after enable, then every eff_period
        enable = 1'b1;
        tick();
        chk("first_sample", 32'(sample), 32'd1);
        period = 16'd3;
        wait_sample(400, n);
        chk("period_100", 32'(n), 32'd100);
        wait_sample(400, n);
        chk("period_clamp_1", 32'(n), 32'd14);
        wait_sample(400, n);
        chk("period_clamp_2", 32'(n), 32'd14);
        enable = 1'b0;
        wait_sample(30, n);
        chk("disabled_no_sample", 32'(n), 32'd30);

        // Two unacknowledged bursts: overrun, read bank untouched
        burst(32'h0000_2000, 12);
        tick();
        chk("ovr_flag_b", 32'(overrun), 32'd1);
        burst(32'h0000_3000, 12);
        tick();
        chk("ovr_flag_c", 32'(overrun), 32'd1);
        chk("ovr_cnt", 32'(frame_cnt), 32'd1);
        chk("ovr_ready", 32'(bus.frame_ready), 32'd1);
        rd_chk("ovr_rd0", 4'd0, 32'h0000_1000);
        rd_chk("ovr_rd11", 4'd11, 32'h0000_100B);
        ack_pulse();
        chk("ack_ready", 32'(bus.frame_ready), 32'd0);
        chk("ack_ovr", 32'(overrun), 32'd0);

        // Short burst: framing error, nothing delivered
        burst(32'h0000_4000, 7);
        tick();
        chk("err_flag", 32'(frame_err), 32'd1);
        chk("err_ready", 32'(bus.frame_ready), 32'd0);
        chk("err_cnt", 32'(frame_cnt), 32'd1);
        burst(32'h0000_5000, 12);
        tick();
        chk("after_err_ready", 32'(bus.frame_ready), 32'd1);
        chk("after_err_cnt", 32'(frame_cnt), 32'd2);
        chk("err_sticky", 32'(frame_err), 32'd1);
        rd_chk("after_err_rd0", 4'd0, 32'h0000_5000);
        rd_chk("after_err_rd11", 4'd11, 32'h0000_500B);

        // Ack in the DONE cycle: frame handed over immediately
        burst(32'h0000_6000, 12);
        ack_pulse();
        chk("ackdone_ready", 32'(bus.frame_ready), 32'd1);
        chk("ackdone_cnt", 32'(frame_cnt), 32'd3);
        chk("ackdone_err_clr", 32'(frame_err), 32'd0);
        chk("ackdone_ovr", 32'(overrun), 32'd0);
        rd_chk("ackdone_rd0", 4'd0, 32'h0000_6000);
        rd_chk("ackdone_rd7", 4'd7, 32'h0000_6007);

        // Back-to-back bursts: second starts in the DONE cycle of the first
        ack_pulse();
        burst(32'h0000_7000, 24);
        tick();
        chk("b2b_cnt", 32'(frame_cnt), 32'd4);
        chk("b2b_ovr", 32'(overrun), 32'd1);
        chk("b2b_ready", 32'(bus.frame_ready), 32'd1);
        rd_chk("b2b_rd0", 4'd0, 32'h0000_7000);
        rd_chk("b2b_rd11", 4'd11, 32'h0000_700B);

        // Asynchronous reset in the middle of a capture
        burst(32'h0000_9000, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cnt", 32'(frame_cnt), 32'd0);
        chk("midrst_ready", 32'(bus.frame_ready), 32'd0);
        chk("midrst_ovr", 32'(overrun), 32'd0);
        chk("midrst_rd_data", bus.rd_data, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        burst(32'h0000_A000, 12);
        tick();
        chk("postrst_ready", 32'(bus.frame_ready), 32'd1);
        chk("postrst_cnt", 32'(frame_cnt), 32'd1);
        rd_chk("postrst_rd3", 4'd3, 32'h0000_A003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cim_frame_ctl.md
Name: cim_frame_ctl

Overview:
- Sequencer and frame collector for the 12-word cascaded-integrator monitor chain.
- Generates the periodic `sample` strobe that snapshots the double integrators.
- Captures the 12-word shift-out burst (`sr_out`/`sr_val`) into a double-buffered frame store.
- Presents completed frames to a host/readout engine through a ready/ack handshake, with overrun and framing-error flags.

Parameters:
- dw, 32, data width of `sr_out`/`rd_data`; matches the chain's dw.
- nw, 12, words per frame (chain length x 2).
- pw, 16, width of the sample-period register.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  1 = generate sample strobes
- period  in  pw  sample period in clk cycles; effective value is max(period, nw+2)
- sample  out  1  one-cycle snapshot strobe to the monitor chain
- sr_out  in  dw  shifted data from the chain
- sr_val  in  1  shift gate from the chain
- rd_addr  in  4  word index 0..nw-1 within the ready frame
- rd_data  out  dw  word from the ready bank; registered, 1-cycle latency
- frame_ready  out  1  a complete frame is held in the read bank
- frame_ack  in  1  host has finished with the read bank
- overrun  out  1  sticky: a completed frame was dropped because the read bank was busy
- frame_err  out  1  sticky: a burst ended with a word count other than nw
- frame_cnt  out  16  count of frames delivered to the read bank; wraps at 2^16

Behaviour:
- Reset (asynchronous on rst_n low): all outputs 0, period counter 0, FSM in IDLE, write bank 0, read bank 1, both banks marked empty.
- Period counter:
  - While enable=1: down-counter; on reaching 0, `sample` is high for exactly 1 cycle and the counter reloads with eff_period-1.
  - First sample fires 1 cycle after enable rises from 0.
  - A change to `period` takes effect only at the next reload.
  - enable=0: counter held at 0, no strobes; a capture already in progress runs to completion.
- Capture FSM:
  - IDLE -> CAP when sr_val=1. The word is written to write_bank[0] and idx becomes 1.
  - In CAP, each cycle with sr_val=1 writes write_bank[idx] and increments idx.
  - When word nw-1 is written -> DONE for 1 cycle.
  - In CAP, sr_val=0 with idx<nw -> set frame_err, discard the frame, return to IDLE.
  - In CAP, sr_val=1 with idx=nw is impossible, because DONE is entered first.
  - sr_val=1 in the DONE cycle is a new burst start: the word is written to the newly selected write bank at index 0 and the FSM -> CAP.
  - `sample` asserted during CAP: no effect on the FSM. The chain serialises, and an eff_period >= nw+2 prevents this.
- DONE handling:
  - If frame_ready=0, or frame_ack=1 in the same cycle: swap banks, set frame_ready=1, frame_cnt+1.
  - Otherwise: keep the banks, set overrun, and let the next burst overwrite the write bank.
- Handshake:
  - frame_ack=1 while frame_ready=1 -> frame_ready=0 the next cycle (unless a same-cycle DONE re-asserts it), and clears overrun and frame_err.
  - frame_ack while frame_ready=0 is ignored.
  - rd_data reflects read_bank[rd_addr] registered 1 cycle after rd_addr.
  - rd_addr >= nw returns 0.
  - The read bank is never written while frame_ready=1.
- Widths: idx is 4 bits; frame_cnt wraps 0xFFFF -> 0 silently.
- Storage: 2 x nw x dw registers, or an inferred dual-port RAM with a registered read.

Decomposition:
- Shared package: FSM state encoding (IDLE, CAP, DONE), NW=12, minimum period NW+2.
- One natural sub-module, cim_period_gen: enable/period/clamp/down-counter producing `sample`.
- The FSM, bank control and storage stay in cim_frame_ctl.

Test Plan:
- Reset mid-capture: rst_n low after word 5 -> all outputs 0 immediately; next clean burst delivers frame_cnt=1.
- period=100, enable=1: sample pulses every 100 cycles, first 1 cycle after enable; period=3 -> pulses every 14 cycles (clamp).
- Chain model returns words 0x1000+i, 12-cycle burst 1 cycle after sample -> frame_ready=1 2 cycles after the last word, frame_cnt=1; rd_addr 0..11 reads 0x1000..0x100B with 1-cycle latency; rd_addr=12 reads 0.
- No ack across two bursts -> overrun=1, frame_cnt stays 1, read bank still holds the first frame; frame_ack -> frame_ready=0, overrun=0.
- Burst of 7 words then sr_val low -> frame_err=1, no frame_ready, frame_cnt unchanged; the next full burst is delivered normally.
- frame_ack in the same cycle as DONE -> frame_ready stays 1, frame_cnt increments, read bank holds the new frame.
